debounce_edge_detect: RTL
=========================

Name: debounce_edge_detect

Overview:
- Conditions a raw asynchronous, bouncy input (push-button or switch) into a clean, synchronous level plus one-cycle rise/fall pulses.
- Sits directly upstream of the D flip-flop / register stages. Its outputs drive their D and clear inputs.
- Consists of a synchronizer chain, a stability counter with a two-state FSM, and registered edge pulses.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (must be >= 2).
- CNT_WIDTH, 16, width of the stability counter.
- STABLE_COUNT, 50000, number of tick_en-qualified cycles the input must stay stable before level changes (1 <= STABLE_COUNT <= 2**CNT_WIDTH).
- RESET_LEVEL, 0, value of level and of every synchronizer flop after reset.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- clear  input  1  reset, synchronous and active-high: takes effect only on a rising clock edge.
- tick_en  input  1  sample-rate enable; the counter advances only when high. Tie high for per-clock counting.
- din  input  1  raw asynchronous input.
- level  output  1  debounced, synchronous level.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- busy  output  1  high while a candidate change is being timed (FSM in CHANGING).

Behaviour:
- Reset (clear high at an edge): sync chain = RESET_LEVEL, level = RESET_LEVEL, rise = fall = 0, busy = 0, count = 0, state = STABLE. Clear has priority over every other event. No pulse is generated by reset or by clear mid-operation.
- Sync chain: din is shifted through SYNC_STAGES flops each edge. s denotes the last stage.
- STABLE state: if s != level, go to CHANGING with count = 0. Otherwise hold.
- CHANGING state, evaluated in priority order:
  - (a) If s == level, return to STABLE with count = 0 (glitch rejected, no pulse).
  - (b) Else if tick_en and count == STABLE_COUNT-1: level <= s, assert rise (if s = 1) or fall (if s = 0) for exactly the next cycle, go to STABLE, count = 0.
  - (c) Else if tick_en: count++.
  - (d) Else hold count.
- Simultaneous glitch-return and terminal count: (a) wins; no toggle.
- rise and fall are registered and change on the same edge as level. They are never both high, and are low in every cycle other than the one following a level update.
- Latency with tick_en = 1 and a clean step on din: level and its pulse update SYNC_STAGES + STABLE_COUNT + 1 edges after the first edge sampling the new din. busy is high from edge SYNC_STAGES+1 until the level update edge.
- STABLE_COUNT = 1: level updates on the first tick_en edge in CHANGING.
- The counter never wraps; it is cleared on every exit from CHANGING.
- Elaboration must fail if a parameter is out of range.

Decomposition:
- Shared package debounce_pkg:
  - state enum typedef {STABLE, CHANGING}
  - default constants for SYNC_STAGES and RESET_LEVEL
- Sub-module sync_chain (parameterised depth, clock/clear, reset value) instantiated once. The FSM, counter and pulse logic stay in the top.

Test Plan:
Bench parameters: SYNC_STAGES=2, STABLE_COUNT=4, tick_en=1, RESET_LEVEL=0 unless stated. N = edge first sampling the new din.
1. Reset: din=1, clear high 2 edges -> level=0, rise=0, fall=0, busy=0 throughout clear.
2. Clean rise: din 0->1, held -> busy=1 from N+3; level=1 and rise=1 at N+7; rise=0 at N+8; fall stays 0.
3. Glitch: din high for 3 edges then low -> busy pulses high, level stays 0, rise/fall never assert.
4. Clean fall from level=1: din 1->0 -> fall=1 for exactly one cycle at N+7, level=0.
5. tick_en gating: tick_en high every other edge -> level rises on the 4th tick_en-high edge after busy asserts; count holds on tick_en-low edges.
6. Clear mid-count (count=2), din still high -> busy=0, level=0, no pulse; after clear drops, level=1 with rise pulse 7 edges after the first non-clear edge.

Source files
------------

// File: rtl/debounce_edge_detect_pkg.sv
// debounce_pkg: shared state encoding and default constants for the debouncer
package debounce_pkg;
  typedef enum logic {STABLE, CHANGING} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic DEF_RESET_LEVEL = 1'b0;
endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// sync_chain: shift-register synchronizer with a synchronous clear to a fixed value
module sync_chain
  import debounce_pkg::*;
#(
  parameter int DEPTH = DEF_SYNC_STAGES,
  parameter logic RESET_VAL = DEF_RESET_LEVEL
) (
  input  logic clock,
  input  logic clear,
  input  logic din,
  output logic q
);
  logic [DEPTH-1:0] r;
  always_ff @(posedge clock)
    r <= clear ? {DEPTH{RESET_VAL}} : {r[DEPTH-2:0], din};
  assign q = r[DEPTH-1];
endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: synchronizes and debounces a raw input into a clean level plus rise/fall pulses
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH = 16,
  parameter int STABLE_COUNT = 50000,
  parameter logic RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic clock,
  input  logic clear,
  input  logic tick_en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);
  if (SYNC_STAGES < 2 || CNT_WIDTH < 1 || CNT_WIDTH > 30 || STABLE_COUNT < 1 ||
      STABLE_COUNT > (1 << CNT_WIDTH)) begin : g_param_check
    $error("debounce_edge_detect: parameter out of range");
  end
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  state_t state;
  logic [CNT_WIDTH-1:0] count;
  logic s;
  // one retiming flop beyond SYNC_STAGES so level lands SYNC_STAGES+STABLE_COUNT+1 edges after din is first sampled
  sync_chain #(.DEPTH(SYNC_STAGES + 1), .RESET_VAL(RESET_LEVEL)) u_sync (
    .clock(clock),
    .clear(clear),
    .din(din),
    .q(s)
  );
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= STABLE;
      count <= '0;
      level <= RESET_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (state == STABLE) begin
        count <= '0;
        if (s != level) state <= CHANGING;
      end else if (s == level) begin
        state <= STABLE;
        count <= '0;
      end else if (tick_en && count == LAST) begin
        level <= s;
        rise <= s;
        fall <= !s;
        state <= STABLE;
        count <= '0;
      end else if (tick_en) begin
        count <= count + 1'b1;
      end
    end
  end
  assign busy = (state == CHANGING);
endmodule
